bit_serial_subtractor: RTL and testbench
========================================

Name: bit_serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes A − B mod 2^WORD_LEN, one bit per handshake, LSB first.
- The inverse-direction companion to the team's 1-bit adder benchmarks. It reuses a combinational full-subtractor cell and adds a borrow register, a bit counter and a registered valid/ready output stage.
- Sits between serial operand sources and serial result sinks in the arithmetic benchmark set.

Parameters:
- WORD_LEN, 8, bits per operand word; legal range 2..64.
- CNT_W, $clog2(WORD_LEN), bit-counter width; derived, not overridable.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand bit pair is valid.
- in_ready  out  1  block accepts an operand bit pair this cycle.
- x  in  1  minuend bit (A), LSB first.
- y  in  1  subtrahend bit (B), LSB first.
- out_valid  out  1  result bit is valid.
- out_ready  in  1  sink accepts the result bit.
- d  out  1  difference bit.
- out_last  out  1  d is the MSB of the word.
- b_out  out  1  final unsigned borrow (A < B); meaningful only when out_last=1, else 0.
- ov  out  1  signed overflow of A − B; meaningful only when out_last=1, else 0.
- busy  out  1  a word is partially consumed (cnt != 0).

Behaviour:
- Reset (async assert, sync release): out_valid=0, d=0, out_last=0, b_out=0, ov=0, borrow register bw=0, cnt=0, busy=0.
- in_ready = !out_valid || out_ready. This is combinational and gives a single-entry pipeline with no bubble under continuous flow.
- Input transfer occurs when in_valid && in_ready. On a transfer:
  - Difference: d_n = x ^ y ^ bw.
  - Next borrow: bw_n = (~x & y) | (~(x ^ y) & bw).
  - The output register loads d=d_n and out_last=(cnt==WORD_LEN−1).
  - When out_last=1: b_out=bw_n and ov=(x ^ y) & (x ^ d_n). Otherwise both are 0.
  - out_valid is set to 1.
  - If cnt==WORD_LEN−1: cnt wraps to 0 and bw clears to 0, so no borrow leaks into the next word. Otherwise cnt=cnt+1 and bw=bw_n.
- If there is no transfer and out_ready=1: out_valid clears to 0. If there is no transfer and out_ready=0: all outputs hold.
- Latency: a result bit is visible the cycle after its input transfer. Throughput is 1 bit/cycle.
- Backpressure: while out_valid && !out_ready, d, out_last, b_out and ov are stable, and in_ready=0.
- Back-to-back words: the first bit of word n+1 may transfer in the same cycle the last bit of word n is consumed.
- in_valid=0 mid-word: cnt and bw hold indefinitely. There is no timeout.
- Reset mid-word: the partial word is discarded. The next accepted bit is treated as bit 0.
- x and y are don't-care when in_valid=0.

Decomposition:
- Package bit_serial_pkg holds:
  - default WORD_LEN;
  - function fs_diff(x, y, bin);
  - function fs_borrow(x, y, bin).
- Sub-module fs_cell: purely combinational 1-bit full subtractor (x, y, bin → d, bout), built from AND/inverter terms. It is instantiated once.

Test Plan (WORD_LEN=4):
- 5−3: x=1,0,1,0; y=1,1,0,0, continuous, out_ready=1 → d=0,1,0,0 (2); out_last on the 4th bit; b_out=0; ov=0.
- 3−5: x=1,1,0,0; y=1,0,1,0 → d=0,1,1,1 (14); b_out=1; ov=0.
- 7−(−8): x=1,1,1,0; y=0,0,0,1 → d=1,1,1,1; b_out=1; ov=1.
- Backpressure: drop out_ready for 3 cycles after bit 1 of the 5−3 word → d=1 held; in_ready=0 for those cycles; final stream is still 0,1,0,0 with no loss or duplication.
- Back-to-back with borrow isolation: 0−1 (x=0,0,0,0; y=1,0,0,0) then immediately 1−0 → d=1,1,1,1 with b_out=1; then d=1,0,0,0 with b_out=0.
- Reset mid-word: assert rst after 2 bits of 3−5 → out_valid, busy and bw go to 0 immediately. A following 5−3 word yields d=0,1,0,0 with b_out=0.

Source files
------------

// File: rtl/bit_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default word length and
// reference full-subtractor equations.
package bit_serial_pkg;

    localparam int WORD_LEN_DEFAULT = 8;

    function automatic logic fs_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    // Borrow out when x < y + bin
    function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

endpackage

// File: rtl/bit_serial_subtractor_fs_cell.sv
// Combinational 1-bit full subtractor (x - y - bin) as sum-of-products of
// AND/inverter terms.
module fs_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic w_nx;
    logic w_ny;
    logic w_nb;

    assign w_nx = ~i_x;
    assign w_ny = ~i_y;
    assign w_nb = ~i_bin;

    // Odd number of ones among x, y, bin
    assign o_d = (w_nx & w_ny & i_bin)
               | (w_nx & i_y  & w_nb)
               | (i_x  & w_ny & w_nb)
               | (i_x  & i_y  & i_bin);

    assign o_bout = (w_nx & i_y) | (w_nx & i_bin) | (i_y & i_bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor A - B, LSB first, with a single-entry
// valid/ready output register and end-of-word borrow/overflow flags.
module bit_serial_subtractor
    import bit_serial_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic x,
    input  logic y,
    output logic out_valid,
    input  logic out_ready,
    output logic d,
    output logic out_last,
    output logic b_out,
    output logic ov,
    output logic busy
);

    localparam int              CNT_W    = $clog2(WORD_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_LEN - 1);

    logic             r_out_valid;
    logic             r_d;
    logic             r_out_last;
    logic             r_b_out;
    logic             r_ov;
    logic             r_bw;
    logic [CNT_W-1:0] r_cnt;

    logic w_in_ready;
    logic w_xfer;
    logic w_last_bit;
    logic w_d;
    logic w_bw_n;
    logic w_ov_n;

    fs_cell u_fs_cell (
        .i_x    (x),
        .i_y    (y),
        .i_bin  (r_bw),
        .o_d    (w_d),
        .o_bout (w_bw_n)
    );

    // Output slot frees up in the same cycle it is drained: no bubble
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_xfer     = in_valid && w_in_ready;
    assign w_last_bit = (r_cnt == LAST_IDX);
    // Signed overflow: operand signs differ and result sign differs from A
    assign w_ov_n     = (x ^ y) & (x ^ w_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_d         <= 1'b0;
            r_out_last  <= 1'b0;
            r_b_out     <= 1'b0;
            r_ov        <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_d         <= w_d;
            r_out_last  <= w_last_bit;
            r_b_out     <= w_last_bit & w_bw_n;
            r_ov        <= w_last_bit & w_ov_n;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Word position and running borrow; both restart at each word boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_bw  <= 1'b0;
        end else if (w_xfer) begin
            if (w_last_bit) begin
                r_cnt <= '0;
                r_bw  <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_bw  <= w_bw_n;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign d         = r_d;
    assign out_last  = r_out_last;
    assign b_out     = r_b_out;
    assign ov        = r_ov;
    assign busy      = (r_cnt != '0);

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Randomized bench for bit_serial_subtractor (WORD_LEN=4) against a word-level
// arithmetic model of A - B.
module tb_bit_serial_subtractor;

    localparam int WL = 4;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic x;
    logic y;
    logic out_valid;
    logic out_ready;
    logic d;
    logic out_last;
    logic b_out;
    logic ov;
    logic busy;

    bit_serial_subtractor #(.WORD_LEN(WL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .out_last  (out_last),
        .b_out     (b_out),
        .ov        (ov),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WL-1:0] a;
        logic [WL-1:0] b;
    } word_t;

    typedef struct {
        logic [3:0]    flags;  // {d, out_last, b_out, ov}
        logic [WL-1:0] a;
        logic [WL-1:0] b;
        logic [WL-1:0] diff;
    } exp_t;

    word_t wq[$];
    exp_t  eq[$];
    bit    ready_sched[$];
    int    bit_idx   = 0;
    int    valid_pct = 100;
    int    ready_pct = 100;
    int    n_checks  = 0;
    int    n_fail    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word-level model: wrapped difference, unsigned borrow, signed overflow
    task automatic push_word(input int a, input int b);
        word_t w;
        exp_t  e;
        int    diff;
        int    sa;
        int    sb;
        logic  bo;
        logic  vo;
        w.a  = WL'(a);
        w.b  = WL'(b);
        diff = (a - b) & ((1 << WL) - 1);
        sa   = (a >= (1 << (WL - 1))) ? a - (1 << WL) : a;
        sb   = (b >= (1 << (WL - 1))) ? b - (1 << WL) : b;
        bo   = (a < b);
        vo   = ((sa - sb) > ((1 << (WL - 1)) - 1)) || ((sa - sb) < -(1 << (WL - 1)));
        wq.push_back(w);
        for (int i = 0; i < WL; i++) begin
            e.a     = w.a;
            e.b     = w.b;
            e.diff  = WL'(diff);
            e.flags = {((diff >> i) & 1) == 1, i == WL - 1,
                       (i == WL - 1) && bo, (i == WL - 1) && vo};
            eq.push_back(e);
        end
    endtask

    // Entered and left at posedge+1; samples DUT outputs on the falling edge
    task automatic run_engine(input int budget);
        int         cyc = 0;
        logic       prev_stall = 1'b0;
        logic [3:0] prev_out = '0;
        exp_t       e;
        while ((wq.size() > 0 || eq.size() > 0) && cyc < budget) begin
            if (wq.size() > 0 && $urandom_range(99) < valid_pct) begin
                in_valid = 1'b1;
                x = wq[0].a[bit_idx];
                y = wq[0].b[bit_idx];
            end else begin
                in_valid = 1'b0;
                x = 1'($urandom);
                y = 1'($urandom);
            end
            if (ready_sched.size() > 0) out_ready = ready_sched.pop_front();
            else                        out_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            check_eq("in_ready", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                check_eq("hold_valid", out_valid, 1'b1);
                check_eq("hold_data", {d, out_last, b_out, ov}, prev_out);
            end
            if (out_valid && out_ready) begin
                if (eq.size() == 0) begin
                    check_eq("extra_bit", out_valid, 1'b0);
                end else begin
                    e = eq.pop_front();
                    check_eq("bit", {d, out_last, b_out, ov}, e.flags);
                    if (e.flags[2])
                        $display("word %0d - %0d -> diff=%0d b_out=%0b ov=%0b",
                                 e.a, e.b, e.diff, b_out, ov);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {d, out_last, b_out, ov};
            if (in_valid && in_ready) begin
                bit_idx++;
                if (bit_idx == WL) begin
                    bit_idx = 0;
                    void'(wq.pop_front());
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("drained", wq.size() + eq.size(), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ready_sched.delete();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = 1'b0;
        y         = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_flags", {d, out_last, b_out, ov}, 4'b0000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // Directed words, continuous flow
        valid_pct = 100;
        ready_pct = 100;
        push_word(5, 3);
        push_word(3, 5);
        push_word(7, 8);
        push_word(0, 1);
        push_word(1, 0);
        run_engine(200);

        // Backpressure: out_ready low for 3 cycles while bit 1 is presented
        push_word(5, 3);
        ready_sched = '{1, 1, 0, 0, 0};
        run_engine(200);

        // Reset partway through 3 - 5
        in_valid  = 1'b1;
        out_ready = 1'b1;
        x = 1'b1; y = 1'b1;
        @(posedge clk); #1;
        x = 1'b1; y = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_busy", busy, 1'b1);
        check_eq("mid_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("arst_valid", out_valid, 1'b0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_d", d, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        bit_idx = 0;
        push_word(5, 3);
        run_engine(200);

        // Random words with random gaps and backpressure
        valid_pct = 70;
        ready_pct = 65;
        for (int i = 0; i < 60; i++) push_word($urandom_range(15), $urandom_range(15));
        push_word(0, 15);
        push_word(15, 0);
        push_word(8, 1);
        push_word(8, 8);
        run_engine(5000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
